// File: rtl/projectile_pkg.sv
// Shared types and constants for the projectile fire controller.
package projectile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLIGHT,
    COOLDOWN
  } launch_state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int Y_FRAME_LIMIT          = 479;

endpackage

// File: rtl/projectile_launcher_edge_detector.sv
// Rising-edge detector for an already-synchronised level input.
module projectile_launcher_edge_detector (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/projectile_launcher.sv
// Single-shot fire controller: latches spawn point, pulses the mover load,
// gates drawing during flight and enforces a frame-counted cooldown.
module projectile_launcher
  import projectile_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int          SHOT_SPEED      = -4 * FIXED_POINT_MULTIPLIER,
  parameter int          SPAWN_OFFSET_X  = 14,
  parameter int          SPAWN_OFFSET_Y  = -8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start_of_frame,
  input  logic               i_fire_key,
  input  logic               i_enable,
  input  logic signed [10:0] i_player_top_left_x,
  input  logic signed [10:0] i_player_top_left_y,
  input  logic               i_projectile_end,
  output logic               o_load_initial_coordinates,
  output logic signed [10:0] o_initial_x,
  output logic signed [10:0] o_initial_y,
  output logic signed [31:0] o_speed,
  output logic               o_projectile_active,
  output logic [7:0]         o_shots_fired
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 1);

  launch_state_t      r_state;
  logic [CNT_W-1:0]   r_cooldown;
  logic               r_load;
  logic signed [10:0] r_initial_x;
  logic signed [10:0] r_initial_y;
  logic signed [31:0] r_speed;
  logic               r_active;
  logic [7:0]         r_shots;

  logic               w_fire_rise;
  logic signed [10:0] w_spawn_x;
  logic signed [10:0] w_spawn_y;
  logic               w_spawn_ok;

  projectile_launcher_edge_detector u_fire_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (i_fire_key),
    .o_rise  (w_fire_rise)
  );

  // Wraps silently in 11 bits; only a non-positive Y suppresses the shot.
  assign w_spawn_x  = i_player_top_left_x + 11'(SPAWN_OFFSET_X);
  assign w_spawn_y  = i_player_top_left_y + 11'(SPAWN_OFFSET_Y);
  assign w_spawn_ok = (w_spawn_y >= 11'sd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cooldown  <= '0;
      r_load      <= 1'b0;
      r_initial_x <= '0;
      r_initial_y <= '0;
      r_speed     <= '0;
      r_active    <= 1'b0;
      r_shots     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fire_rise && i_enable && w_spawn_ok) begin
            r_initial_x <= w_spawn_x;
            r_initial_y <= w_spawn_y;
            r_load      <= 1'b1;
            r_state     <= LOAD;
          end
        end
        // End flag is ignored here: the mover still holds the previous shot.
        LOAD: begin
          r_load   <= 1'b0;
          r_active <= 1'b1;
          r_speed  <= 32'(SHOT_SPEED);
          if (r_shots != 8'hFF) begin
            r_shots <= r_shots + 8'd1;
          end
          r_state  <= FLIGHT;
        end
        FLIGHT: begin
          if (i_projectile_end) begin
            r_active   <= 1'b0;
            r_speed    <= '0;
            r_cooldown <= CNT_W'(COOLDOWN_FRAMES);
            r_state    <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (i_start_of_frame) begin
            r_cooldown <= r_cooldown - CNT_W'(1);
            if (r_cooldown == CNT_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_load_initial_coordinates = r_load;
  assign o_initial_x                = r_initial_x;
  assign o_initial_y                = r_initial_y;
  assign o_speed                    = r_speed;
  assign o_projectile_active        = r_active;
  assign o_shots_fired              = r_shots;

endmodule

// File: tb/tb_projectile_launcher.sv
// Directed self-checking bench for projectile_launcher.
module tb_projectile_launcher;

  logic               clk = 1'b0;
  logic               reset;
  logic               sof;
  logic               fire;
  logic               enable;
  logic signed [10:0] px;
  logic signed [10:0] py;
  logic               pend;
  logic               load;
  logic signed [10:0] ix;
  logic signed [10:0] iy;
  logic signed [31:0] speed;
  logic               active;
  logic [7:0]         shots;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  projectile_launcher dut (
    .i_clk                      (clk),
    .i_reset                    (reset),
    .i_start_of_frame           (sof),
    .i_fire_key                 (fire),
    .i_enable                   (enable),
    .i_player_top_left_x        (px),
    .i_player_top_left_y        (py),
    .i_projectile_end           (pend),
    .o_load_initial_coordinates (load),
    .o_initial_x                (ix),
    .o_initial_y                (iy),
    .o_speed                    (speed),
    .o_projectile_active        (active),
    .o_shots_fired              (shots)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // One-cycle fire edge; on return the LOAD cycle (if any) is visible.
  task automatic press();
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
  endtask

  task automatic end_shot();
    pend = 1'b1;
    tick();
    pend = 1'b0;
  endtask

  int loads;

  initial begin
    reset = 1'b0; sof = 1'b0; fire = 1'b0; enable = 1'b1;
    px = 11'sd100; py = 11'sd200; pend = 1'b0;
    do_reset(3);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_speed", speed, 32'd0);
    chk("rst_shots", 32'(shots), 32'd0);

    // Launch from (100,200); end flag during LOAD must be ignored.
    press();
    chk("t2_load", 32'(load), 32'd1);
    chk("t2_ix", 32'(ix), 32'd114);
    chk("t2_iy", 32'(iy), 32'd192);
    chk("t2_active_in_load", 32'(active), 32'd0);
    pend = 1'b1;
    tick();
    pend = 1'b0;
    chk("t2_load_drop", 32'(load), 32'd0);
    chk("t2_active", 32'(active), 32'd1);
    chk("t2_speed", speed, 32'hFFFF_FF00);
    chk("t2_shots", 32'(shots), 32'd1);
    px = 11'sd300; py = 11'sd50;
    press();
    chk("t2_flight_edge_dropped", 32'(load), 32'd0);
    tick();
    chk("t2_still_active", 32'(active), 32'd1);
    chk("t2_ix_held", 32'(ix), 32'd114);
    chk("t2_iy_held", 32'(iy), 32'd192);

    // Reset mid-flight.
    do_reset(3);
    chk("t1_active", 32'(active), 32'd0);
    chk("t1_speed", speed, 32'd0);
    chk("t1_shots", 32'(shots), 32'd0);

    // Cooldown: end coincides with a frame pulse, counter still loads full.
    px = 11'sd100; py = 11'sd200;
    press();
    chk("t4_load", 32'(load), 32'd1);
    tick();
    pend = 1'b1; sof = 1'b1;
    tick();
    pend = 1'b0; sof = 1'b0;
    chk("t4_retired", 32'(active), 32'd0);
    chk("t4_speed0", speed, 32'd0);
    repeat (3) frame();
    press();
    chk("t4_after3", 32'(load), 32'd0);
    repeat (4) frame();
    press();
    chk("t4_after7", 32'(load), 32'd0);
    frame();
    press();
    chk("t4_after8", 32'(load), 32'd1);
    tick();
    chk("t4_shots", 32'(shots), 32'd2);

    // Held key across retire and cooldown never re-fires.
    end_shot();
    repeat (8) frame();
    press();
    chk("t3_launch", 32'(load), 32'd1);
    fire = 1'b1;
    tick();
    end_shot();
    repeat (8) frame();
    loads = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      loads += int'(load);
    end
    chk("t3_held_loads", 32'(loads), 32'd0);
    fire = 1'b0;
    tick();
    loads = 0;
    fire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      loads += int'(load);
    end
    fire = 1'b0;
    chk("t3_repress_loads", 32'(loads), 32'd1);
    chk("t3_shots", 32'(shots), 32'd4);

    // Spawn Y = -3 is suppressed; a good Y afterwards proves FSM stayed IDLE.
    do_reset(1);
    py = 11'sd5;
    press();
    chk("t5_no_load", 32'(load), 32'd0);
    tick();
    chk("t5_shots", 32'(shots), 32'd0);
    chk("t5_inactive", 32'(active), 32'd0);
    py = 11'sd200;
    press();
    chk("t5_then_load", 32'(load), 32'd1);
    tick();
    end_shot();
    repeat (8) frame();

    // Saturation: 1 shot so far, 252 more reach 253, then 3 more.
    for (int i = 0; i < 252; i++) begin
      press();
      tick();
      end_shot();
      repeat (8) frame();
    end
    chk("t6_253", 32'(shots), 32'd253);
    for (int i = 0; i < 3; i++) begin
      press();
      tick();
      end_shot();
      repeat (8) frame();
    end
    chk("t6_sat", 32'(shots), 32'd255);
    enable = 1'b0;
    press();
    chk("t6_disabled", 32'(load), 32'd0);
    tick();
    chk("t6_disabled_inactive", 32'(active), 32'd0);
    enable = 1'b1;
    press();
    chk("t6_reenabled", 32'(load), 32'd1);
    tick();
    chk("t6_sat_hold", 32'(shots), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
